// File: rtl/cache_cpu_master.sv
// cache_cpu_master
//   CPU-side initiator for direct_cache. Commands are queued in a small FIFO,
//   then issued one at a time on the cache CPU port. Each command produces a
//   one-cycle response pulse carrying read data, hit status and timeout.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    command push handshake (ready = FIFO not full)
//   cmd_is_rd/addr/wdata  command contents (wdata ignored for reads)
//   cmd_count          FIFO occupancy
//   rsp_valid          one-cycle completion pulse, no backpressure
//   rsp_is_rd/rdata/hit/timeout  completion info, held until the next pulse
//   addr, addr_en, is_rd  cache request (addr_en held ISSUE_CYCLES cycles)
//   data, data_vld     shared bidirectional bus (driven only while issuing a write)
//   is_hit, cache_busy cache status inputs
module cache_cpu_master #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int CMD_DEPTH    = 4,
  parameter int ISSUE_CYCLES = 2,
  parameter int TIMEOUT      = 255,
  localparam int CNT_W       = $clog2(CMD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [CNT_W-1:0]      cmd_count,
  output logic                  rsp_valid,
  output logic                  rsp_is_rd,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_hit,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_en,
  output logic                  is_rd,
  inout  wire  [DATA_WIDTH-1:0] data,
  inout  wire                   data_vld,
  input  logic                  is_hit,
  input  logic                  cache_busy
);

  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int ISS_W  = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(CMD_DEPTH);
  localparam logic [ISS_W-1:0]  ISS_LAST  = ISS_W'(ISSUE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic                  is_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t             mem_q [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;
  cmd_t             head;
  state_e           state_q;

  assign push = cmd_valid && !full_q;
  // Pop coincides with IDLE->ISSUE; a busy cache leaves the head in place.
  assign pop  = (state_q == S_IDLE) && !empty_q && !cache_busy;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{is_rd: cmd_is_rd, addr: cmd_addr, wdata: cmd_wdata};
  end

  assign cmd_ready = !full_q;
  assign cmd_count = count_q;

  // ----------------------------------------------------------------- FSM
  logic [ISS_W-1:0]      issue_cnt_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  is_rd_q, addr_en_q, drive_q;
  logic                  rsp_valid_q, rsp_is_rd_q, rsp_hit_q, rsp_timeout_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      issue_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      is_rd_q       <= 1'b0;
      addr_en_q     <= 1'b0;
      drive_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_is_rd_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q     <= S_ISSUE;
            addr_q      <= head.addr;
            is_rd_q     <= head.is_rd;
            wdata_q     <= head.wdata;
            addr_en_q   <= 1'b1;
            drive_q     <= !head.is_rd;
            issue_cnt_q <= '0;
          end
        end
        S_ISSUE: begin
          if (issue_cnt_q == ISS_LAST) begin
            state_q    <= S_WAIT;
            addr_en_q  <= 1'b0;
            drive_q    <= 1'b0;   // bus released for the whole WAIT phase
            wait_cnt_q <= '0;
          end else begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          // The edge closing a WAIT cycle counts that cycle as elapsed, so a
          // write may finish at the first WAIT edge when the cache is idle.
          // Completion is tested before timeout so it wins on a tie.
          if (is_rd_q && (data_vld == 1'b1)) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_is_rd_q   <= 1'b1;
            rsp_rdata_q   <= data;
            rsp_hit_q     <= is_hit;
            rsp_timeout_q <= 1'b0;
          end else if (!is_rd_q && !cache_busy) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_is_rd_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_hit_q     <= is_hit;
            rsp_timeout_q <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_is_rd_q   <= is_rd_q;
            rsp_rdata_q   <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_timeout_q <= 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr        = addr_q;
  assign addr_en     = addr_en_q;
  assign is_rd       = is_rd_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_is_rd   = rsp_is_rd_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_timeout = rsp_timeout_q;

  // Bus is driven only from a register that is set solely during a write ISSUE.
  assign data     = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign data_vld = drive_q ? 1'b1 : 1'bz;

endmodule
